sobel_host_ctrl: RTL and testbench
==================================

Name: sobel_host_ctrl

Overview:
- Host-side counterpart of the obfuscated Sobel accelerator's block-level ap_ctrl_hs handshake and output-memory port.
- Drives ap_start and working_key into the accelerator and waits for ap_done.
- Acts as the memory responder on the outdata write port: counts written pixels, checksums them, and forwards each write as a registered stream.
- Sits between the system register interface and the accelerator; includes a watchdog so that a wrong key cannot hang the system.

Parameters:
- ADDR_W, 18, outdata address width ({Y[8:0], X[8:0]}).
- EXPECTED_WRITES, 260100, pixel writes per correct frame (510 x 510 interior).
- TIMEOUT_CYCLES, 33554432, run cycles before the watchdog fires (32-bit compare).

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- cmd_start  in  1  one-cycle pulse; starts a frame
- cmd_key  in  3  key captured at cmd_start
- cmd_clear  in  1  clears sticky status flags (ERR -> IDLE)
- busy  out  1  high in START/RUN
- done_pulse  out  1  one cycle, frame completed
- timeout  out  1  sticky, watchdog fired
- count_mismatch  out  1  sticky, write count != EXPECTED_WRITES at done
- stray_write  out  1  sticky, write seen outside START/RUN
- wr_count  out  32  writes in last/current frame
- checksum  out  32  wrapping sum of written pixel bytes
- acc_ap_start  out  1  to accelerator
- acc_ap_done  in  1
- acc_ap_idle  in  1
- acc_ap_ready  in  1
- acc_working_key  out  3  latched key, stable for the whole frame
- acc_out_address0  in  ADDR_W
- acc_out_ce0  in  1
- acc_out_we0  in  1
- acc_out_d0  in  8
- m_valid  out  1  registered write forward, no backpressure
- m_addr  out  ADDR_W
- m_data  out  8

Behaviour:
- Reset (async, ap_rst_n=0): every output and register is 0; state IDLE. Reset mid-frame drops acc_ap_start immediately.
- FSM states: IDLE, START, RUN, DONE, ERR (one-hot).
- IDLE:
  - cmd_start=1 -> START next edge.
  - On the same edge: latch cmd_key to acc_working_key, clear wr_count/checksum/count_mismatch, clear the watchdog, set acc_ap_start=1 (registered).
- START:
  - acc_ap_start held 1.
  - acc_ap_ready=1 sampled -> acc_ap_start=0 on that edge.
  - If acc_ap_done=1 is also sampled on that edge -> DONE; otherwise -> RUN.
  - The accelerator must never see acc_ap_start=1 in the cycle after ap_ready; this prevents an unintended restart.
- RUN:
  - acc_ap_done=1 -> DONE.
  - acc_ap_ready without done is impossible for this accelerator; ignore it.
- Watchdog:
  - A 32-bit counter increments every cycle in START/RUN.
  - Reaching TIMEOUT_CYCLES-1 with no ap_done that cycle -> ERR, acc_ap_start=0, timeout=1.
  - ap_done and watchdog expiry in the same cycle: done wins.
- DONE:
  - done_pulse=1 for exactly this one cycle.
  - count_mismatch set if the final wr_count != EXPECTED_WRITES; the final count includes any write in the done cycle.
  - -> IDLE.
- ERR:
  - Holds until cmd_clear -> IDLE; clearing also clears timeout and stray_write.
  - cmd_start in ERR is ignored.
- cmd_start in START/RUN/DONE: ignored, with no effect on the key.
- Write responder:
  - A cycle with acc_out_ce0 & acc_out_we0 while in START/RUN is a valid write: wr_count+=1, checksum+=zero-extended d0 (mod 2^32).
  - On the next edge: m_valid=1, m_addr=address0, m_data=d0. Latency is 1 cycle; consecutive writes produce consecutive m_valid.
  - A write in the ap_done cycle counts.
  - Writes in IDLE/DONE/ERR are not counted or forwarded; they set stray_write.
  - ce0 with we0=0 is ignored.
- wr_count and checksum saturate: none. Both wrap silently.
- wr_count and checksum hold their values after DONE until the next cmd_start.
- acc_ap_idle is used only for the assertion that it is 1 whenever the FSM is in IDLE after the first frame; it does not affect behaviour.

Decomposition:
- Shared package sobel_ctrl_pkg:
  - FSM one-hot state constants.
  - KEY_W=3.
  - Pixel-address field widths and a {Y,X} address pack/unpack.
  - The default frame constants (510 interior, 260100).
- One natural sub-module: sobel_wr_monitor. It holds the write counter, checksum, forward register and stray detection, and is enabled by the FSM's in-run signal.

Test Plan:
- Normal frame: bench accelerator model with EXPECTED_WRITES=4; cmd_start, cmd_key=3'b000; model writes d0=10,20,30,40, then ap_done=ap_ready=1. Required: acc_ap_start falls the edge after ready; done_pulse once; wr_count=4; checksum=100; count_mismatch=0; four m_valid beats with matching addr/data.
- Restart hazard: model asserts ap_ready/ap_done in the first cycle after start. Required: DONE entered, acc_ap_start=0 the next cycle, model never re-enters its run state.
- Watchdog: TIMEOUT_CYCLES=16, model never sends done. Required: timeout=1 and acc_ap_start=0 after 16 busy cycles; busy=0; cmd_start ignored; cmd_clear -> IDLE and timeout=0.
- Mismatch and wrap: EXPECTED_WRITES=4, model writes 3 bytes of 255 each. Required: count_mismatch=1, checksum=765.
- Stray and ignored writes: in IDLE, we0=ce0=1 -> stray_write=1, wr_count unchanged, no m_valid; ce0=1, we0=0 during RUN -> not counted.
- Reset mid-frame: ap_rst_n=0 during RUN with acc_ap_start=1. Required: all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sobel_ctrl_pkg.sv
// Shared types and constants for the Sobel accelerator host controller.
// Covers FSM state encoding, key width, frame constants and pixel-address packing.
package sobel_ctrl_pkg;

    localparam int unsigned KEY_W        = 3;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned PIX_W        = 9;
    localparam int unsigned FRAME_DIM    = 510;
    localparam int unsigned FRAME_PIXELS = FRAME_DIM * FRAME_DIM;

    typedef enum logic [4:0] {
        StIdle  = 5'b00001,
        StStart = 5'b00010,
        StRun   = 5'b00100,
        StDone  = 5'b01000,
        StErr   = 5'b10000
    } state_e;

    function automatic logic [2*PIX_W-1:0] pack_addr(input logic [PIX_W-1:0] y,
                                                     input logic [PIX_W-1:0] x);
        return {y, x};
    endfunction

    function automatic logic [PIX_W-1:0] addr_y(input logic [2*PIX_W-1:0] a);
        return a[2*PIX_W-1:PIX_W];
    endfunction

    function automatic logic [PIX_W-1:0] addr_x(input logic [2*PIX_W-1:0] a);
        return a[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_wr_monitor.sv
// Output-memory write responder: counts and checksums in-run writes, forwards
// them as a registered stream, and flags writes that arrive outside a run.
module sobel_wr_monitor
    import sobel_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 18
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_run,
    input  logic              i_frame_start,
    input  logic              i_clear_stray,
    input  logic              i_ce,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [31:0]       o_count,
    output logic [31:0]       o_count_next,
    output logic [31:0]       o_checksum,
    output logic              o_stray,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              w_wr;
    logic              w_hit;
    logic [31:0]       w_count_next;
    logic [31:0]       w_sum_next;
    logic [31:0]       r_count;
    logic [31:0]       r_sum;
    logic              r_stray;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    always_comb begin
        w_wr  = i_ce & i_we;
        w_hit = w_wr & i_in_run;
        if (i_frame_start) begin
            w_count_next = '0;
            w_sum_next   = '0;
        end else begin
            // Both accumulators wrap silently modulo 2^32.
            w_count_next = r_count + 32'(w_hit);
            w_sum_next   = r_sum + (w_hit ? 32'(i_data) : 32'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_sum   <= '0;
            r_stray <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_count <= w_count_next;
            r_sum   <= w_sum_next;
            r_valid <= w_hit;
            if (w_hit) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
            if (w_wr && !i_in_run) begin
                r_stray <= 1'b1;
            end else if (i_clear_stray) begin
                r_stray <= 1'b0;
            end
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_checksum   = r_sum;
    assign o_stray      = r_stray;
    assign o_valid      = r_valid;
    assign o_addr       = r_addr;
    assign o_data       = r_data;

endmodule

// File: rtl/sobel_host_ctrl.sv
// Host-side ap_ctrl_hs driver for the keyed Sobel accelerator, with watchdog
// and an output-memory write responder.
module sobel_host_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W          = 18,
    parameter int unsigned EXPECTED_WRITES = FRAME_PIXELS,
    parameter int unsigned TIMEOUT_CYCLES  = 33554432
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cmd_start,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic              cmd_clear,
    output logic              busy,
    output logic              done_pulse,
    output logic              timeout,
    output logic              count_mismatch,
    output logic              stray_write,
    output logic [31:0]       wr_count,
    output logic [31:0]       checksum,
    output logic              acc_ap_start,
    input  logic              acc_ap_done,
    input  logic              acc_ap_idle,
    input  logic              acc_ap_ready,
    output logic [KEY_W-1:0]  acc_working_key,
    input  logic [ADDR_W-1:0] acc_out_address0,
    input  logic              acc_out_ce0,
    input  logic              acc_out_we0,
    input  logic [DATA_W-1:0] acc_out_d0,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data
);

    localparam logic [31:0] WdogLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] ExpCount = 32'(EXPECTED_WRITES);

    state_e           r_state, w_state_next;
    logic             r_start, w_start_next;
    logic [KEY_W-1:0] r_key, w_key_next;
    logic [31:0]      r_wdog, w_wdog_next;
    logic             r_timeout, w_timeout_next;
    logic             r_mismatch, w_mismatch_next;
    logic             r_frame_done, w_frame_done_next;
    logic             w_frame_start;
    logic             w_clear;
    logic             w_in_run;
    logic             w_expired;
    logic [31:0]      w_count_next;

    assign w_in_run  = (r_state == StStart) || (r_state == StRun);
    assign w_expired = (r_wdog == WdogLast);

    always_comb begin
        w_state_next      = r_state;
        w_start_next      = r_start;
        w_key_next        = r_key;
        w_wdog_next       = r_wdog;
        w_timeout_next    = r_timeout;
        w_mismatch_next   = r_mismatch;
        w_frame_done_next = r_frame_done;
        w_frame_start     = 1'b0;
        w_clear           = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cmd_start) begin
                    w_state_next    = StStart;
                    w_start_next    = 1'b1;
                    w_key_next      = cmd_key;
                    w_wdog_next     = '0;
                    w_mismatch_next = 1'b0;
                    w_frame_start   = 1'b1;
                end
            end
            StStart: begin
                w_wdog_next = r_wdog + 32'd1;
                // Done beats the watchdog; ap_start must fall on the ready edge.
                if (acc_ap_ready && acc_ap_done) begin
                    w_state_next    = StDone;
                    w_start_next    = 1'b0;
                    w_mismatch_next = (w_count_next != ExpCount);
                end else if (w_expired) begin
                    w_state_next   = StErr;
                    w_start_next   = 1'b0;
                    w_timeout_next = 1'b1;
                end else if (acc_ap_ready) begin
                    w_state_next = StRun;
                    w_start_next = 1'b0;
                end
            end
            StRun: begin
                w_wdog_next = r_wdog + 32'd1;
                if (acc_ap_done) begin
                    w_state_next    = StDone;
                    w_mismatch_next = (w_count_next != ExpCount);
                end else if (w_expired) begin
                    w_state_next   = StErr;
                    w_start_next   = 1'b0;
                    w_timeout_next = 1'b1;
                end
            end
            StDone: begin
                w_state_next      = StIdle;
                w_frame_done_next = 1'b1;
            end
            StErr: begin
                if (cmd_clear) begin
                    w_state_next   = StIdle;
                    w_timeout_next = 1'b0;
                    w_clear        = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_start_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state      <= StIdle;
            r_start      <= 1'b0;
            r_key        <= '0;
            r_wdog       <= '0;
            r_timeout    <= 1'b0;
            r_mismatch   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_start      <= w_start_next;
            r_key        <= w_key_next;
            r_wdog       <= w_wdog_next;
            r_timeout    <= w_timeout_next;
            r_mismatch   <= w_mismatch_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    sobel_wr_monitor #(
        .ADDR_W (ADDR_W)
    ) u_wr_monitor (
        .i_clk         (ap_clk),
        .i_rst_n       (ap_rst_n),
        .i_in_run      (w_in_run),
        .i_frame_start (w_frame_start),
        .i_clear_stray (w_clear),
        .i_ce          (acc_out_ce0),
        .i_we          (acc_out_we0),
        .i_addr        (acc_out_address0),
        .i_data        (acc_out_d0),
        .o_count       (wr_count),
        .o_count_next  (w_count_next),
        .o_checksum    (checksum),
        .o_stray       (stray_write),
        .o_valid       (m_valid),
        .o_addr        (m_addr),
        .o_data        (m_data)
    );

    assign busy            = w_in_run;
    assign done_pulse      = (r_state == StDone);
    assign timeout         = r_timeout;
    assign count_mismatch  = r_mismatch;
    assign acc_ap_start    = r_start;
    assign acc_working_key = r_key;

    // Once a frame has completed, an idle host implies an idle accelerator.
    a_idle_after_frame: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        (r_state == StIdle && r_frame_done) |-> acc_ap_idle);

endmodule

// File: tb/tb_sobel_host_ctrl.sv
// Directed bench for sobel_host_ctrl: a per-cycle vector table for two frames,
// then hand sequences for restart hazard, watchdog and asynchronous reset.
module tb_sobel_host_ctrl;
    import sobel_ctrl_pkg::*;

    localparam int unsigned AW = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic [2:0]    cmd_key = '0;
    logic          cmd_clear = 1'b0;
    logic          busy, done_pulse, timeout, count_mismatch, stray_write;
    logic [31:0]   wr_count, checksum;
    logic          acc_ap_start;
    logic          ap_done = 1'b0, ap_idle = 1'b1, ap_ready = 1'b0;
    logic [2:0]    working_key;
    logic [AW-1:0] out_addr = '0;
    logic          out_ce = 1'b0, out_we = 1'b0;
    logic [7:0]    out_d = '0;
    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sobel_host_ctrl #(
        .ADDR_W          (AW),
        .EXPECTED_WRITES (4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .ap_clk           (clk),
        .ap_rst_n         (rst_n),
        .cmd_start        (cmd_start),
        .cmd_key          (cmd_key),
        .cmd_clear        (cmd_clear),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .timeout          (timeout),
        .count_mismatch   (count_mismatch),
        .stray_write      (stray_write),
        .wr_count         (wr_count),
        .checksum         (checksum),
        .acc_ap_start     (acc_ap_start),
        .acc_ap_done      (ap_done),
        .acc_ap_idle      (ap_idle),
        .acc_ap_ready     (ap_ready),
        .acc_working_key  (working_key),
        .acc_out_address0 (out_addr),
        .acc_out_ce0      (out_ce),
        .acc_out_we0      (out_we),
        .acc_out_d0       (out_d),
        .m_valid          (m_valid),
        .m_addr           (m_addr),
        .m_data           (m_data)
    );

    typedef struct {
        logic          st;
        logic [2:0]    key;
        logic          idle;
        logic          rdy;
        logic          dn;
        logic          ce;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    d;
        logic          e_busy;
        logic          e_apst;
        logic          e_dp;
        logic          e_mv;
        logic [AW-1:0] e_maddr;
        logic [7:0]    e_mdata;
        logic [31:0]   e_cnt;
        logic [31:0]   e_sum;
        logic          e_mis;
        logic          e_stray;
        logic [2:0]    e_key;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic [2:0] key, input logic idle,
                       input logic rdy, input logic dn, input logic ce, input logic we,
                       input logic [AW-1:0] addr, input logic [7:0] d,
                       input logic e_busy, input logic e_apst, input logic e_dp,
                       input logic e_mv, input logic [AW-1:0] e_maddr,
                       input logic [7:0] e_mdata, input logic [31:0] e_cnt,
                       input logic [31:0] e_sum, input logic e_mis, input logic e_stray,
                       input logic [2:0] e_key);
        vec_t v;
        v = '{st, key, idle, rdy, dn, ce, we, addr, d, e_busy, e_apst, e_dp, e_mv,
              e_maddr, e_mdata, e_cnt, e_sum, e_mis, e_stray, e_key};
        vecs.push_back(v);
    endtask

    initial begin
        int n_busy;
        logic last_apst;
        logic [AW-1:0] a11, a12, a13, a14, a22, a31, a32, a33, a44;
        a11 = pack_addr(9'd1, 9'd1);
        a12 = pack_addr(9'd1, 9'd2);
        a13 = pack_addr(9'd1, 9'd3);
        a14 = pack_addr(9'd1, 9'd4);
        a22 = pack_addr(9'd2, 9'd2);
        a31 = pack_addr(9'd3, 9'd1);
        a32 = pack_addr(9'd3, 9'd2);
        a33 = pack_addr(9'd3, 9'd3);
        a44 = pack_addr(9'd4, 9'd4);

        //  st key idl rdy dn ce we addr d   | busy apst dp mv maddr md cnt sum mis stray key
        // Frame 1: four writes 10+20+30+40, then done+ready.
        add(1, 0, 1, 0, 0, 0, 0, 0,   0,    1, 1, 0, 0, 0,   0,   0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,   0,    1, 1, 0, 0, 0,   0,   0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0,   0,    1, 0, 0, 0, 0,   0,   0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, a11, 10,   1, 0, 0, 1, a11, 10,  1, 10,  0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, a12, 20,   1, 0, 0, 1, a12, 20,  2, 30,  0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, a13, 99,   1, 0, 0, 0, 0,   0,   2, 30,  0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, a13, 30,   1, 0, 0, 1, a13, 30,  3, 60,  0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, a14, 40,   1, 0, 0, 1, a14, 40,  4, 100, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0,   0,    0, 0, 1, 0, 0,   0,   4, 100, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0,   0,    0, 0, 0, 0, 0,   0,   4, 100, 0, 0, 0);
        // Stray write while idle.
        add(0, 0, 1, 0, 0, 1, 1, a22, 77,   0, 0, 0, 0, 0,   0,   4, 100, 0, 1, 0);
        // Frame 2: key 5, restart attempt in START ignored, 3 x 255 with last in done cycle.
        add(1, 5, 1, 0, 0, 0, 0, 0,   0,    1, 1, 0, 0, 0,   0,   0, 0,   0, 1, 5);
        add(1, 3, 0, 1, 0, 0, 0, 0,   0,    1, 0, 0, 0, 0,   0,   0, 0,   0, 1, 5);
        add(0, 0, 0, 0, 0, 1, 1, a31, 255,  1, 0, 0, 1, a31, 255, 1, 255, 0, 1, 5);
        add(0, 0, 0, 0, 0, 1, 1, a32, 255,  1, 0, 0, 1, a32, 255, 2, 510, 0, 1, 5);
        add(0, 0, 0, 0, 1, 1, 1, a33, 255,  0, 0, 1, 1, a33, 255, 3, 765, 1, 1, 5);
        add(0, 0, 1, 0, 0, 0, 0, 0,   0,    0, 0, 0, 0, 0,   0,   3, 765, 1, 1, 5);

        // Reset state.
        #2;
        chk("reset_apst", acc_ap_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", wr_count, 0);
        chk("reset_flags", {timeout, count_mismatch, stray_write, m_valid}, 0);
        #10 rst_n = 1'b1;

        foreach (vecs[i]) begin
            cmd_start = vecs[i].st;
            cmd_key   = vecs[i].key;
            ap_idle   = vecs[i].idle;
            ap_ready  = vecs[i].rdy;
            ap_done   = vecs[i].dn;
            out_ce    = vecs[i].ce;
            out_we    = vecs[i].we;
            out_addr  = vecs[i].addr;
            out_d     = vecs[i].d;
            step();
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_apst", i), acc_ap_start, vecs[i].e_apst);
            chk($sformatf("v%0d_done_pulse", i), done_pulse, vecs[i].e_dp);
            chk($sformatf("v%0d_m_valid", i), m_valid, vecs[i].e_mv);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].e_maddr);
                chk($sformatf("v%0d_m_data", i), m_data, vecs[i].e_mdata);
            end
            chk($sformatf("v%0d_wr_count", i), wr_count, vecs[i].e_cnt);
            chk($sformatf("v%0d_checksum", i), checksum, vecs[i].e_sum);
            chk($sformatf("v%0d_mismatch", i), count_mismatch, vecs[i].e_mis);
            chk($sformatf("v%0d_stray", i), stray_write, vecs[i].e_stray);
            chk($sformatf("v%0d_key", i), working_key, vecs[i].e_key);
        end
        {cmd_start, ap_ready, ap_done, out_ce, out_we} = '0;

        // Restart hazard: ready and done in the first START cycle.
        cmd_start = 1'b1; cmd_key = 3'd2; ap_idle = 1'b1;
        step();
        chk("hz_busy", busy, 1);
        chk("hz_apst", acc_ap_start, 1);
        cmd_start = 1'b0; ap_idle = 1'b0; ap_ready = 1'b1; ap_done = 1'b1;
        step();
        chk("hz_done_pulse", done_pulse, 1);
        chk("hz_apst_fall", acc_ap_start, 0);
        chk("hz_mismatch", count_mismatch, 1);
        chk("hz_count", wr_count, 0);
        ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hz_no_restart%0d", i), {busy, acc_ap_start, done_pulse}, 0);
        end

        // Watchdog: accelerator never answers.
        cmd_start = 1'b1; cmd_key = 3'd6;
        step();
        cmd_start = 1'b0; ap_idle = 1'b0;
        n_busy = 0;
        last_apst = 1'b0;
        while (busy && n_busy < 40) begin
            n_busy++;
            last_apst = acc_ap_start;
            step();
        end
        chk("wd_busy_cycles", n_busy, 16);
        chk("wd_apst_held", last_apst, 1);
        chk("wd_timeout", timeout, 1);
        chk("wd_apst_drop", acc_ap_start, 0);
        chk("wd_busy", busy, 0);
        cmd_start = 1'b1; cmd_key = 3'd1;
        step();
        cmd_start = 1'b0;
        chk("err_start_ignored", {busy, acc_ap_start, timeout}, 3'b001);
        chk("err_key_kept", working_key, 6);
        ap_idle = 1'b1; cmd_clear = 1'b1;
        step();
        cmd_clear = 1'b0;
        chk("clr_timeout", timeout, 0);
        chk("clr_stray", stray_write, 0);
        chk("clr_busy", busy, 0);
        cmd_start = 1'b1; cmd_key = 3'd0;
        step();
        chk("post_clr_start", {busy, acc_ap_start}, 2'b11);
        cmd_start = 1'b0; ap_idle = 1'b0; ap_ready = 1'b1; ap_done = 1'b1;
        step();
        chk("post_clr_done", done_pulse, 1);
        ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
        step();

        // Asynchronous reset mid-frame with ap_start high and a forwarded write.
        cmd_start = 1'b1; cmd_key = 3'd7;
        step();
        cmd_start = 1'b0; ap_idle = 1'b0;
        out_ce = 1'b1; out_we = 1'b1; out_addr = a44; out_d = 8'd9;
        step();
        out_ce = 1'b0; out_we = 1'b0;
        chk("pre_rst_active", {acc_ap_start, m_valid, busy}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_apst", acc_ap_start, 0);
        chk("rst_key", working_key, 0);
        chk("rst_outs", {busy, done_pulse, timeout, count_mismatch, stray_write, m_valid}, 0);
        chk("rst_count_sum", {wr_count, checksum}, 0);
        chk("rst_stream", {m_addr, m_data}, 0);
        ap_idle = 1'b1;
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
